// File: rtl/pmem_if.sv
// pmem_if: line-transfer bus between the cache arbiter and physical memory.
//   pmem_read / pmem_write : request, held by the master until pmem_resp
//   pmem_address           : byte address; the low 4 bits select a byte within a line
//   pmem_wdata             : 128-bit write line
//   pmem_resp              : one-cycle completion pulse from the slave
//   pmem_rdata             : 128-bit read line, valid in the pmem_resp cycle
// Handshake: a request is raised and held until the master samples pmem_resp
// high. It is dropped on that same edge. A request that is still high in the
// following cycle is treated as a new transaction.
interface pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency physical-memory model, slave end of pmem_if.
// It accepts one line read or write at a time. Each transaction completes
// LATENCY cycles after acceptance with a single-cycle pmem_resp pulse.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   bus          : pmem_if slave modport
//   busy         : a transaction is accepted but has not yet completed (BUSY/RESP)
//   protocol_err : sticky flag. It is set by read+write at acceptance or by a
//                  request dropped in BUSY. Only rst clears it.
//   read_count   : completed reads, saturating at 0xFFFF
//   write_count  : completed writes, saturating at 0xFFFF
//   fsm_state    : current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module pmem_responder #(
  parameter int LINE_BITS = 8,
  parameter int LATENCY   = 10
) (
  input  logic        clk,
  input  logic        rst,
  pmem_if.slave       bus,
  output logic        busy,
  output logic        protocol_err,
  output logic [15:0] read_count,
  output logic [15:0] write_count,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q;
  logic                   op_write_q;
  logic [LINE_BITS-1:0]   idx_q;
  logic [127:0]           wdata_q;
  logic [127:0]           rdata_q;
  logic                   err_q;
  logic [15:0]            rd_cnt_q, wr_cnt_q;
  logic [127:0]           mem [2**LINE_BITS];

  logic                   req;
  logic                   accept;
  logic                   commit;
  logic                   commit_write;
  logic [LINE_BITS-1:0]   commit_idx;
  logic [127:0]           commit_wdata;

  assign req    = bus.pmem_read | bus.pmem_write;
  assign accept = (state_q == IDLE) && req;

  // The array is accessed on the edge that enters RESP. With LATENCY=1 that
  // edge is also the accept edge. On that edge the capture registers are not
  // yet loaded, so the live bus values are used instead.
  assign commit       = (state_d == RESP) && (state_q != RESP);
  assign commit_write = (state_q == IDLE) ? bus.pmem_write : op_write_q;
  assign commit_idx   = (state_q == IDLE) ? bus.pmem_address[LINE_BITS+3:4] : idx_q;
  assign commit_wdata = (state_q == IDLE) ? bus.pmem_wdata : wdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = (LATENCY == 1) ? RESP : BUSY;
      // The counter reaches zero on this edge, so the transition to RESP
      // happens here. RESP then falls exactly LATENCY cycles after acceptance.
      BUSY: if (cnt_q <= 32'd1) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy          = 1'b0;
    bus.pmem_resp = 1'b0;
    case (state_q)
      BUSY: busy = 1'b1;
      RESP: begin
        busy          = 1'b1;
        bus.pmem_resp = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      cnt_q      <= 32'(LATENCY - 1);
      op_write_q <= bus.pmem_write;   // read+write together counts as a write
      idx_q      <= bus.pmem_address[LINE_BITS+3:4];
      wdata_q    <= bus.pmem_wdata;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

  // Read data, error flag and traffic counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if ((accept && bus.pmem_read && bus.pmem_write) || (state_q == BUSY && !req))
        err_q <= 1'b1;
      if (commit) begin
        if (commit_write) begin
          if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end else begin
          rdata_q <= mem[commit_idx];
          if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
    end
  end

  // Line array. Reset leaves it untouched. A write aborted by rst never commits.
  always_ff @(posedge clk) begin
    if (!rst && commit && commit_write)
      mem[commit_idx] <= commit_wdata;
  end

  assign bus.pmem_rdata = rdata_q;
  assign protocol_err   = err_q;
  assign read_count     = rd_cnt_q;
  assign write_count    = wr_cnt_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: directed bench for pmem_responder.
// Instance a uses LATENCY=10 and covers the main scenarios. Instance b uses
// LATENCY=1 and covers back-to-back requests.
module tb_pmem_responder;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  pmem_if ia ();
  pmem_if ib ();

  logic        busy_a, err_a, busy_b, err_b;
  logic [15:0] rc_a, wc_a, rc_b, wc_b;
  logic [1:0]  st_a, st_b;

  pmem_responder #(.LINE_BITS(8), .LATENCY(10)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ia.slave), .busy(busy_a), .protocol_err(err_a),
    .read_count(rc_a), .write_count(wc_a), .fsm_state(st_a)
  );

  pmem_responder #(.LINE_BITS(8), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ib.slave), .busy(busy_b), .protocol_err(err_b),
    .read_count(rc_b), .write_count(wc_b), .fsm_state(st_b)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D3 = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] D4 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D5 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance a starting at a negedge, hold it until
  // pmem_resp, then drop it. On return the bench is at the negedge after the
  // response cycle. lat is the cycle count from acceptance to pmem_resp (-1 on
  // timeout).
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, output int lat,
                        output logic [127:0] rdv, output logic busy_ok);
    int n;
    ia.pmem_read    = rd;
    ia.pmem_write   = wr;
    ia.pmem_address = addr;
    ia.pmem_wdata   = wd;
    busy_ok = 1'b1;
    lat = -1;
    rdv = '0;
    n = 0;
    @(posedge clk);
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy_a !== 1'b1) busy_ok = 1'b0;
      if (ia.pmem_resp === 1'b1) begin
        lat = n;
        rdv = ia.pmem_rdata;
        break;
      end
    end
    ia.pmem_read  = 1'b0;
    ia.pmem_write = 1'b0;
    @(negedge clk);
  endtask

  int          lat;
  logic [127:0] rdv;
  logic        bok;
  int          pulses;
  int          n;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ia.pmem_read = 1'b0; ia.pmem_write = 1'b0; ia.pmem_address = '0; ia.pmem_wdata = '0;
    ib.pmem_read = 1'b0; ib.pmem_write = 1'b0; ib.pmem_address = '0; ib.pmem_wdata = '0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_resp",  128'(ia.pmem_resp), 128'd0);
    check("rst_busy",  128'(busy_a), 128'd0);
    check("rst_rdata", ia.pmem_rdata, 128'd0);
    check("rst_err",   128'(err_a), 128'd0);
    check("rst_rc",    128'(rc_a), 128'd0);
    check("rst_wc",    128'(wc_a), 128'd0);
    check("rst_state", 128'(st_a), 128'd0);

    // Write line 0x1234: latency 10, one-cycle pulse, rdata left unchanged
    do_req(1'b0, 1'b1, 16'h1234, D1, lat, rdv, bok);
    check("t1_latency", 128'(lat), 128'd10);
    check("t1_busy",    128'(bok), 128'd1);
    check("t1_width",   128'(ia.pmem_resp), 128'd0);
    check("t1_rdata_unchanged", rdv, 128'd0);
    check("t1_wc",      128'(wc_a), 128'd1);
    check("t1_idle_busy", 128'(busy_a), 128'd0);

    // Two reads of the same line through different low address bits
    do_req(1'b1, 1'b0, 16'h1238, '0, lat, rdv, bok);
    check("t2_rd1_data", rdv, D1);
    check("t2_rd1_lat",  128'(lat), 128'd10);
    do_req(1'b1, 1'b0, 16'h1234, '0, lat, rdv, bok);
    check("t2_rd2_data", rdv, D1);
    check("t2_rc",       128'(rc_a), 128'd2);
    check("t2_err",      128'(err_a), 128'd0);

    // Read and write together: treated as a write, sticky error
    do_req(1'b1, 1'b1, 16'h2000, D2, lat, rdv, bok);
    check("t4_lat", 128'(lat), 128'd10);
    check("t4_err", 128'(err_a), 128'd1);
    check("t4_wc",  128'(wc_a), 128'd2);
    check("t4_rc",  128'(rc_a), 128'd2);
    do_req(1'b1, 1'b0, 16'h2000, '0, lat, rdv, bok);
    check("t4_readback",   rdv, D2);
    check("t4_err_sticky", 128'(err_a), 128'd1);

    // Reset clears the flag and counters
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("t5_err_cleared", 128'(err_a), 128'd0);
    check("t5_rc_cleared",  128'(rc_a), 128'd0);

    // Write aborted by reset in BUSY: no response, array unchanged
    ia.pmem_write = 1'b1; ia.pmem_address = 16'h2000; ia.pmem_wdata = D3;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    ia.pmem_write = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (ia.pmem_resp === 1'b1) pulses++;
    end
    check("t5_no_resp", 128'(pulses), 128'd0);
    check("t5_wc",      128'(wc_a), 128'd0);
    do_req(1'b1, 1'b0, 16'h2000, '0, lat, rdv, bok);
    check("t5_old_data", rdv, D2);

    // Address aliasing modulo the array size
    do_req(1'b0, 1'b1, 16'h0010, D4, lat, rdv, bok);
    do_req(1'b1, 1'b0, 16'h1010, '0, lat, rdv, bok);
    check("t6_alias", rdv, D4);
    check("t6_wc",    128'(wc_a), 128'd1);

    // Request dropped in BUSY: the write still completes and the error is set
    ia.pmem_write = 1'b1; ia.pmem_address = 16'h0030; ia.pmem_wdata = D5;
    @(posedge clk);
    @(negedge clk);
    ia.pmem_write = 1'b0;
    ia.pmem_wdata = '0;
    n = 1;
    lat = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (ia.pmem_resp === 1'b1) begin
        lat = n;
        break;
      end
    end
    check("drop_lat", 128'(lat), 128'd10);
    check("drop_err", 128'(err_a), 128'd1);
    @(negedge clk);
    check("drop_wc",  128'(wc_a), 128'd2);
    do_req(1'b1, 1'b0, 16'h0030, '0, lat, rdv, bok);
    check("drop_data", rdv, D5);

    // Write counter saturation
    force dut_a.wr_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut_a.wr_cnt_q;
    @(negedge clk);
    check("sat_preload", 128'(wc_a), 128'hFFFE);
    do_req(1'b0, 1'b1, 16'h0040, D1, lat, rdv, bok);
    check("sat_reach", 128'(wc_a), 128'hFFFF);
    do_req(1'b0, 1'b1, 16'h0040, D2, lat, rdv, bok);
    check("sat_hold", 128'(wc_a), 128'hFFFF);

    // LATENCY=1, read held continuously: a response every other cycle
    ib.pmem_read = 1'b1;
    ib.pmem_address = 16'h0000;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_resp_%0d", i), 128'(ib.pmem_resp), 128'(i % 2));
      check($sformatf("b2b_busy_%0d", i), 128'(busy_b), 128'(i % 2));
    end
    ib.pmem_read = 1'b0;
    check("b2b_rc",  128'(rc_b), 128'd4);
    check("b2b_err", 128'(err_b), 128'd0);
    @(negedge clk);
    @(negedge clk);
    check("b2b_stop", 128'(rc_b), 128'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
